// File: rtl/network_scheduler_pkg.sv
// Shared types and constants for the inference-datapath scheduler.
// Vector elements are signed Q8.8.
package network_scheduler_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic int unsigned id_width(input int unsigned r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/network_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping from R-1 back to 0.
module rr_arbiter
  import network_scheduler_pkg::*;
#(
  parameter int unsigned R  = 4,
  parameter int unsigned IW = id_width(R)
) (
  input  logic [R-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [R-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < R; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= R) cand = cand - R;
      cand_idx = IW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/network_scheduler.sv
// Round-robin sharing of one start/done inference datapath among R requesters,
// with a per-run watchdog and a tagged valid/ready response channel.
module network_scheduler
  import network_scheduler_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned R       = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [R-1:0]             req_valid,
  input  logic [R*N*DATA_W-1:0]    req_x,
  output logic [R-1:0]             req_ready,
  output logic                     net_start,
  output logic [N*DATA_W-1:0]      net_x,
  input  logic [N*DATA_W-1:0]      net_y,
  input  logic                     net_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [id_width(R)-1:0]   rsp_id,
  output logic [N*DATA_W-1:0]      rsp_y,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int unsigned IW = id_width(R);
  localparam int unsigned VW = N * DATA_W;
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(R - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [VW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [R-1:0]  arb_grant;
  logic [IW-1:0] arb_idx;
  logic          arb_any;
  logic [VW-1:0] sel_x;

  rr_arbiter #(.R(R), .IW(IW)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    sel_x = '0;
    for (int unsigned k = 0; k < R; k++) begin
      if (IW'(k) == arb_idx) sel_x = req_x[k*VW +: VW];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    y_d       = y_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    net_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          x_d       = sel_x;
          id_d      = arb_idx;
          ptr_d     = (arb_idx == ID_LAST) ? '0 : arb_idx + 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        net_start = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over expiry in the same cycle; the counter is
        // held on exit so it never wraps
        if (net_done) begin
          y_d     = net_y;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign net_x   = x_q;
  assign rsp_id  = id_q;
  assign rsp_y   = y_q;
  assign rsp_err = err_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_network_scheduler.sv
// Directed bench for network_scheduler with a delay-programmable datapath stub
// that returns each input element doubled.
module tb_network_scheduler;
  import network_scheduler_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned R   = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned VW  = N * DATA_W;
  localparam logic [15:0] Q_ONE = 16'(1 << FRAC_W);

  logic            clk, rst_n;
  logic [R-1:0]    req_valid, req_ready;
  logic [R*VW-1:0] req_x;
  logic            net_start, net_done, rsp_valid, rsp_ready, rsp_err, busy;
  logic [VW-1:0]   net_x, net_y, rsp_y;
  logic [1:0]      rsp_id;

  logic [VW-1:0] xv [R];
  logic [VW-1:0] yv [R];

  int checks, errors, start_cnt, s0;

  logic [VW-1:0] s_y;
  logic          s_done, s_act, inj_done;
  int            s_cnt, stub_dly;
  bit            stub_hang;

  network_scheduler #(.N(N), .R(R), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .net_start (net_start),
    .net_x     (net_x),
    .net_y     (net_y),
    .net_done  (net_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign req_x    = {xv[3], xv[2], xv[1], xv[0]};
  assign net_done = s_done | inj_done;
  assign net_y    = inj_done ? {N{16'hBAD0}} : s_y;

  function automatic logic [VW-1:0] dbl(input logic [VW-1:0] x);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = x[i*16 +: 16] << 1;
    return r;
  endfunction

  // done is high in the cycle stub_dly cycles after the start pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_act  <= 1'b0;
      s_cnt  <= 0;
      s_done <= 1'b0;
      s_y    <= '0;
    end else begin
      s_done <= 1'b0;
      if (net_start) begin
        s_act <= 1'b1;
        s_cnt <= 1;
      end else if (s_act) begin
        if (s_cnt == stub_dly - 1 && !stub_hang) begin
          s_done <= 1'b1;
          s_y    <= dbl(net_x);
          s_act  <= 1'b0;
        end
        s_cnt <= s_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (net_start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic request(input logic [R-1:0] v, input int g, input bit keep, input string tag);
    req_valid = v;
    #1;
    check({tag, "_ready"}, req_ready, 64'(1) << g);
    s0 = start_cnt;
    tick;
    if (!keep) req_valid = '0;
    #1;
    check({tag, "_start"}, net_start, 1);
    check({tag, "_netx"}, net_x, xv[g]);
    check({tag, "_ready_off"}, req_ready, 0);
  endtask

  task automatic wait_rsp(input int exp_n, input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 60) begin
      tick;
      n++;
    end
    check({tag, "_lat"}, n, exp_n);
    check({tag, "_starts"}, start_cnt - s0, 1);
  endtask

  task automatic finish_rsp(input int id, input logic [VW-1:0] y, input logic err, input string tag);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_y"}, rsp_y, y);
    check({tag, "_err"}, rsp_err, err);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_valid_after"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; start_cnt = 0; s0 = 0;
    xv[0] = {16'h0000, -Q_ONE, 16'(2 * Q_ONE), Q_ONE};
    xv[1] = 64'h0080_FF80_0040_0010;
    xv[2] = 64'h1000_0300_F000_0001;
    xv[3] = 64'h0001_0002_0003_0004;
    yv[0] = 64'h0000_FE00_0400_0200;
    yv[1] = 64'h0100_FF00_0080_0020;
    yv[2] = 64'h2000_0600_E000_0002;
    yv[3] = 64'h0002_0004_0006_0008;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; inj_done = 1'b0;
    stub_dly = 5; stub_hang = 1'b0;

    #3;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_net_start", net_start, 0);
    check("rst_net_x", net_x, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_y", rsp_y, 0);
    tick; tick;
    rst_n = 1'b1;

    // 1: single request, 5-cycle datapath
    request(4'b0001, 0, 0, "t1");
    wait_rsp(6, "t1");
    finish_rsp(0, yv[0], 1'b0, "t1");

    // 2: all valid, fairness from a fresh pointer
    do_reset;
    rsp_ready = 1'b1; stub_dly = 2; req_valid = '1;
    #1;
    for (int k = 0; k < 6; k++) begin
      int n;
      n = 0;
      while (req_ready == 0 && n < 10) begin
        tick;
        n++;
      end
      check("t2_grant", req_ready, 64'(1) << (k % 4));
      s0 = start_cnt;
      tick;
      if (k == 5) req_valid = '0;
      check("t2_ready_off", req_ready, 0);
      check("t2_netx", net_x, xv[k % 4]);
      wait_rsp(3, "t2");
      check("t2_id", rsp_id, k % 4);
      tick;
    end
    rsp_ready = 1'b0;
    check("t2_idle", busy, 0);

    // 3: watchdog, then a normal run (pointer is 2)
    stub_hang = 1'b1;
    request(4'b0010, 1, 0, "t3a");
    wait_rsp(17, "t3a");
    finish_rsp(1, '0, 1'b1, "t3a");
    stub_hang = 1'b0; stub_dly = 3;
    request(4'b1000, 3, 0, "t3b");
    wait_rsp(4, "t3b");
    finish_rsp(3, yv[3], 1'b0, "t3b");

    // 4: response back-pressure with another requester pending
    stub_dly = 4;
    request(4'b0101, 0, 1, "t4a");
    wait_rsp(5, "t4a");
    for (int c = 0; c < 10; c++) begin
      tick;
      check("t4_valid", rsp_valid, 1);
      check("t4_y", rsp_y, yv[0]);
      check("t4_id", rsp_id, 0);
      check("t4_no_ready", req_ready, 0);
      check("t4_no_start", net_start, 0);
      check("t4_netx", net_x, xv[0]);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    request(4'b0101, 2, 0, "t4b");
    wait_rsp(5, "t4b");
    finish_rsp(2, yv[2], 1'b0, "t4b");

    // 5: stray done in IDLE and late done after timeout
    inj_done = 1'b1;
    tick; tick;
    check("t5_idle_valid", rsp_valid, 0);
    check("t5_idle_busy", busy, 0);
    inj_done = 1'b0;
    stub_hang = 1'b1;
    request(4'b0010, 1, 0, "t5a");
    wait_rsp(17, "t5a");
    inj_done = 1'b1;
    tick; tick;
    check("t5_late_y", rsp_y, 0);
    check("t5_late_err", rsp_err, 1);
    inj_done = 1'b0;
    finish_rsp(1, '0, 1'b1, "t5a");
    inj_done = 1'b1;
    tick; tick;
    check("t5_post_valid", rsp_valid, 0);
    inj_done = 1'b0;
    stub_hang = 1'b0; stub_dly = 2;
    request(4'b0001, 0, 0, "t5b");
    wait_rsp(3, "t5b");
    finish_rsp(0, yv[0], 1'b0, "t5b");

    // 6: reset while waiting on the datapath
    stub_hang = 1'b1;
    request(4'b0010, 1, 0, "t6a");
    tick; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_netx", net_x, 0);
    check("t6_valid", rsp_valid, 0);
    check("t6_start", net_start, 0);
    s0 = start_cnt;
    tick;
    rst_n = 1'b1;
    tick;
    check("t6_no_start", start_cnt - s0, 0);
    check("t6_no_rsp", rsp_valid, 0);
    stub_hang = 1'b0; stub_dly = 2;
    request(4'b0100, 2, 0, "t6b");
    wait_rsp(3, "t6b");
    finish_rsp(2, yv[2], 1'b0, "t6b");
    request(4'b0011, 0, 0, "t6c");
    wait_rsp(3, "t6c");
    finish_rsp(0, yv[0], 1'b0, "t6c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
